// File: rtl/freq_counter.sv
// Gated frequency counter. Counts rising edges of an asynchronous input over
// back-to-back gates of GATE_CYCLES clk_in cycles and publishes each count.
module freq_counter #(
  parameter int unsigned GATE_CYCLES = 32'd50_000_000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             ovf,
  output logic             gate
);

  localparam logic [31:0]      GATE_LAST = 32'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {IDLE, GATE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       sync_pipe;   // [0],[1] synchronizer, [2] edge-detect history
  logic             sig_rise;
  logic [31:0]      gate_cnt, gate_cnt_nxt;
  logic [CNT_W-1:0] edge_cnt, edge_cnt_nxt, cnt_inc, freq_nxt;
  logic             sat, sat_nxt, sat_inc, ovf_nxt, fv_nxt;

  // Synchronize sig_in and keep one extra sample for rising-edge detection.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[1:0], sig_in};
  end

  assign sig_rise = sync_pipe[1] & ~sync_pipe[2];
  assign gate     = (state == GATE);

  // Edge count including this cycle's edge; holds at max instead of wrapping.
  always_comb begin
    cnt_inc = edge_cnt + {{(CNT_W-1){1'b0}}, sig_rise};
    sat_inc = sat;
    if (sig_rise && (edge_cnt == CNT_MAX)) begin
      cnt_inc = edge_cnt;
      sat_inc = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state, gate counting and result publication.
  always_comb begin
    state_nxt    = state;
    gate_cnt_nxt = gate_cnt;
    edge_cnt_nxt = edge_cnt;
    sat_nxt      = sat;
    freq_nxt     = freq;
    ovf_nxt      = ovf;
    fv_nxt       = 1'b0;
    case (state)
      IDLE: begin
        gate_cnt_nxt = '0;
        edge_cnt_nxt = '0;
        sat_nxt      = 1'b0;
        if (enable) state_nxt = GATE;
      end
      GATE: begin
        if (!enable) begin
          // Abort: partial count is discarded, last result stays visible.
          state_nxt    = IDLE;
          gate_cnt_nxt = '0;
          edge_cnt_nxt = '0;
          sat_nxt      = 1'b0;
        end else if (gate_cnt == GATE_LAST) begin
          // Close gate (its last edge included) and open the next one at once.
          freq_nxt     = cnt_inc;
          ovf_nxt      = sat_inc;
          fv_nxt       = 1'b1;
          gate_cnt_nxt = '0;
          edge_cnt_nxt = '0;
          sat_nxt      = 1'b0;
        end else begin
          gate_cnt_nxt = gate_cnt + 32'd1;
          edge_cnt_nxt = cnt_inc;
          sat_nxt      = sat_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sat        <= 1'b0;
      freq       <= '0;
      ovf        <= 1'b0;
      freq_valid <= 1'b0;
    end else begin
      gate_cnt   <= gate_cnt_nxt;
      edge_cnt   <= edge_cnt_nxt;
      sat        <= sat_nxt;
      freq       <= freq_nxt;
      ovf        <= ovf_nxt;
      freq_valid <= fv_nxt;
    end
  end

endmodule

// File: tb/tb_freq_counter.sv
// Scoreboard bench for freq_counter: two instances (CNT_W=8 and CNT_W=5) share
// stimulus; expected results are queued with their due cycle when stimulus is set up.
module tb_freq_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       sig_in = 1'b0;
  logic [7:0] freq8;
  logic [4:0] freq5;
  logic       fv8, fv5, ovf8, ovf5, gate8, gate5;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int half = 0;
  int ph = 0;

  typedef struct {
    int cyc;
    bit cmp;
    int f8;
    bit o8;
    int f5;
    bit o5;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  freq_counter #(.GATE_CYCLES(100), .CNT_W(8)) dut8 (
    .clk_in(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig_in),
    .freq(freq8), .freq_valid(fv8), .ovf(ovf8), .gate(gate8));

  freq_counter #(.GATE_CYCLES(100), .CNT_W(5)) dut5 (
    .clk_in(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig_in),
    .freq(freq5), .freq_valid(fv5), .ovf(ovf5), .gate(gate5));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  // Queue an expected result for a gate whose true edge count is known.
  task automatic push_exp(input int at, input int count);
    exp_t e;
    e.cyc = at;
    e.cmp = 1'b1;
    e.f8  = count;
    e.o8  = 1'b0;
    e.f5  = (count > 31) ? 31 : count;
    e.o5  = (count > 31);
    q.push_back(e);
  endtask

  // Queue a pulse whose timing matters but whose count is mixed-rate.
  task automatic push_time(input int at);
    exp_t e;
    e.cyc = at;
    e.cmp = 1'b0;
    e.f8 = 0; e.o8 = 1'b0; e.f5 = 0; e.o5 = 1'b0;
    q.push_back(e);
  endtask

  // Advance n falling edges; sig_in toggles every 'half' cycles when half != 0.
  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      if (half != 0) begin
        ph++;
        if (ph >= half) begin
          sig_in = ~sig_in;
          ph = 0;
        end
      end
    end
  endtask

  task automatic to_cyc(input int t);
    while (cyc < t) run(1);
  endtask

  // Result monitor: every pulse must match the head of the queue in time and value.
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() > 0 && q[0].cyc < cyc) begin
        chk("pulse_missed", cyc, q[0].cyc);
        void'(q.pop_front());
      end else if (q.size() > 0 && q[0].cyc == cyc) begin
        mon_e = q.pop_front();
        chk("fv8", fv8, 1);
        chk("fv5", fv5, 1);
        if (mon_e.cmp) begin
          chk("freq8", freq8, mon_e.f8);
          chk("ovf8", ovf8, mon_e.o8);
          chk("freq5", freq5, mon_e.f5);
          chk("ovf5", ovf5, mon_e.o5);
        end
      end else if (fv8 || fv5) begin
        chk("fv_unexpected", {fv8, fv5}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, r;
    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_freq8", freq8, 0);
    chk("rst_fv8", fv8, 0);
    chk("rst_ovf8", ovf8, 0);
    chk("rst_gate8", gate8, 0);
    chk("rst_freq5", freq5, 0);
    run(2);
    #2 rst_n = 1'b1;
    run(3);

    // Period-10 input: 10 edges per gate, first pulse 101 cycles after enable.
    half = 5; ph = 0;
    run(20);
    c = cyc;
    enable = 1'b1;
    chk("gate_idle", gate8, 0);
    push_exp(c + 101, 10);
    push_exp(c + 201, 10);
    push_exp(c + 301, 10);
    run(1);
    chk("gate_open", gate8, 1);
    to_cyc(c + 305);
    enable = 1'b0;
    run(1);
    chk("gate_abort1", gate8, 0);

    // Single rising edge then held high: 1 then 0.
    half = 0; sig_in = 1'b0;
    run(10);
    c = cyc;
    enable = 1'b1;
    push_exp(c + 101, 1);
    push_exp(c + 201, 0);
    to_cyc(c + 10);
    sig_in = 1'b1;
    to_cyc(c + 205);
    enable = 1'b0;
    run(1);

    // Max rate saturates the narrow counter; a later slow gate clears ovf.
    sig_in = 1'b0; half = 1; ph = 0;
    run(10);
    c = cyc;
    enable = 1'b1;
    push_exp(c + 101, 50);
    push_time(c + 201);
    push_exp(c + 301, 10);
    to_cyc(c + 150);
    half = 5; ph = 0;
    to_cyc(c + 305);
    enable = 1'b0;
    run(1);

    // Gate boundaries: edge on last cycle of gate 0, edge on first cycle of gate 2.
    half = 0; sig_in = 1'b0;
    run(10);
    c = cyc;
    enable = 1'b1;
    push_exp(c + 101, 1);
    push_exp(c + 201, 0);
    push_exp(c + 301, 1);
    to_cyc(c + 98);
    sig_in = 1'b1;
    to_cyc(c + 150);
    sig_in = 1'b0;
    to_cyc(c + 199);
    sig_in = 1'b1;
    to_cyc(c + 305);
    enable = 1'b0;
    run(1);

    // Abort at gate_cnt=50: no pulse, result held; re-enable measures afresh.
    sig_in = 1'b0; half = 5; ph = 0;
    run(10);
    c = cyc;
    enable = 1'b1;
    to_cyc(c + 51);
    enable = 1'b0;
    run(1);
    chk("gate_abort_mid", gate8, 0);
    to_cyc(c + 150);
    chk("freq8_held", freq8, 1);
    chk("freq5_held", freq5, 1);
    c = cyc;
    enable = 1'b1;
    push_exp(c + 101, 10);

    // Asynchronous reset mid-gate, then restart with enable held.
    to_cyc(c + 140);
    half = 0; ph = 0; sig_in = 1'b0;
    to_cyc(c + 145);
    chk("gate_pre_rst", gate8, 1);
    chk("freq8_pre_rst", freq8, 10);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_freq8", freq8, 0);
    chk("arst_freq5", freq5, 0);
    chk("arst_gate8", gate8, 0);
    chk("arst_fv8", fv8, 0);
    chk("arst_ovf8", ovf8, 0);
    run(5);
    r = cyc;
    half = 5; ph = 0;
    #2 rst_n = 1'b1;
    push_exp(r + 101, 10);
    to_cyc(r + 110);

    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
